// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings for the iterative 8x8 multiplier controller
// State codes are visible on state_out, so their values are fixed.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    LSB       = 3'b001,
    MID       = 3'b010,
    MSB       = 3'b011,
    CALC_DONE = 3'b100,
    ERR       = 3'b101
  } state_e;

  // Operand nibble select: bit 1 picks the a nibble, bit 0 picks the b nibble
  localparam logic [1:0] SEL_ALO_BLO = 2'b00;
  localparam logic [1:0] SEL_ALO_BHI = 2'b01;
  localparam logic [1:0] SEL_AHI_BLO = 2'b10;
  localparam logic [1:0] SEL_AHI_BHI = 2'b11;

  localparam logic [1:0] SHIFT_0 = 2'b00;
  localparam logic [1:0] SHIFT_4 = 2'b01;
  localparam logic [1:0] SHIFT_8 = 2'b10;

  localparam logic [1:0] CNT_STEP0 = 2'b00;
  localparam logic [1:0] CNT_STEP1 = 2'b01;
  localparam logic [1:0] CNT_STEP2 = 2'b10;
  localparam logic [1:0] CNT_STEP3 = 2'b11;

endpackage

// File: rtl/mult_control_fsm.sv
// rtl/mult_control_fsm.sv - sequencer for an 8x8 multiply built from a 4x4 multiplier
// Mealy controller: outputs depend on the current state plus start and count.
module mult_control_fsm
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  input  logic [1:0] count,
  output logic       done,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic [2:0] state_out
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Any step whose count disagrees with the expected step, or a start
  // seen mid-calculation, parks the sequencer in ERR until restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LSB;
      end
      LSB: begin
        if (!start && count == CNT_STEP0) state_d = MID;
        else                              state_d = ERR;
      end
      MID: begin
        if (!start && count == CNT_STEP1)      state_d = MID;
        else if (!start && count == CNT_STEP2) state_d = MSB;
        else                                   state_d = ERR;
      end
      MSB: begin
        if (!start && count == CNT_STEP3) state_d = CALC_DONE;
        else                              state_d = ERR;
      end
      CALC_DONE: begin
        if (start) state_d = ERR;
        else       state_d = IDLE;
      end
      ERR: begin
        if (start) state_d = LSB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done      = 1'b0;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    input_sel = SEL_ALO_BLO;
    shift_sel = SHIFT_0;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          clk_ena = 1'b1;
          sclr_n  = 1'b0;
        end
      end
      LSB: begin
        if (!start && count == CNT_STEP0) begin
          input_sel = SEL_ALO_BLO;
          shift_sel = SHIFT_0;
          clk_ena   = 1'b1;
        end
      end
      MID: begin
        // Both cross products land at the same weight (shift by 4)
        if (!start && count == CNT_STEP1) begin
          input_sel = SEL_ALO_BHI;
          shift_sel = SHIFT_4;
          clk_ena   = 1'b1;
        end else if (!start && count == CNT_STEP2) begin
          input_sel = SEL_AHI_BLO;
          shift_sel = SHIFT_4;
          clk_ena   = 1'b1;
        end
      end
      MSB: begin
        if (!start && count == CNT_STEP3) begin
          input_sel = SEL_AHI_BHI;
          shift_sel = SHIFT_8;
          clk_ena   = 1'b1;
        end
      end
      CALC_DONE: begin
        if (!start) done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_mult_control_fsm.sv
// tb/tb_mult_control_fsm.sv - directed-vector bench for mult_control_fsm
// Inputs change just after the falling edge; outputs are checked before the next rising edge.
module tb_mult_control_fsm;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       start;
  logic [1:0] count;
  logic       done;
  logic       clk_ena;
  logic       sclr_n;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic [2:0] state_out;

  int n_vec = 0;
  int n_bad = 0;

  // {done, clk_ena, sclr_n, input_sel, shift_sel}
  localparam logic [6:0] O_DEF   = 7'b0_0_1_00_00;
  localparam logic [6:0] O_START = 7'b0_1_0_00_00;
  localparam logic [6:0] O_LSB   = 7'b0_1_1_00_00;
  localparam logic [6:0] O_MID1  = 7'b0_1_1_01_01;
  localparam logic [6:0] O_MID2  = 7'b0_1_1_10_01;
  localparam logic [6:0] O_MSB   = 7'b0_1_1_11_10;
  localparam logic [6:0] O_DONE  = 7'b1_0_1_00_00;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LSB  = 3'b001;
  localparam logic [2:0] S_MID  = 3'b010;
  localparam logic [2:0] S_MSB  = 3'b011;
  localparam logic [2:0] S_DONE = 3'b100;
  localparam logic [2:0] S_ERR  = 3'b101;

  mult_control_fsm dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start),
    .count     (count),
    .done      (done),
    .clk_ena   (clk_ena),
    .sclr_n    (sclr_n),
    .input_sel (input_sel),
    .shift_sel (shift_sel),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Apply one input vector for a cycle and check the Mealy response of the current state
  task automatic step(input string tag, input logic s, input logic [1:0] c,
                      input logic [2:0] exp_state, input logic [6:0] exp_out);
    @(negedge clk);
    start = s;
    count = c;
    #1;
    check_vec({tag, ".state"}, {13'd0, state_out}, {13'd0, exp_state});
    check_vec({tag, ".outs"}, {9'd0, done, clk_ena, sclr_n, input_sel, shift_sel}, {9'd0, exp_out});
  endtask

  initial begin
    reset_a = 1'b0;
    start   = 1'b0;
    count   = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_vec("rst.state", {13'd0, state_out}, {13'd0, S_IDLE});
    check_vec("rst.outs", {9'd0, done, clk_ena, sclr_n, input_sel, shift_sel}, {9'd0, O_DEF});
    reset_a = 1'b1;

    // Nominal run
    step("nom.idle", 1'b1, 2'b00, S_IDLE, O_START);
    step("nom.lsb",  1'b0, 2'b00, S_LSB,  O_LSB);
    step("nom.mid1", 1'b0, 2'b01, S_MID,  O_MID1);
    step("nom.mid2", 1'b0, 2'b10, S_MID,  O_MID2);
    step("nom.msb",  1'b0, 2'b11, S_MSB,  O_MSB);
    step("nom.done", 1'b0, 2'b00, S_DONE, O_DONE);
    step("nom.back", 1'b0, 2'b00, S_IDLE, O_DEF);

    // Shortened MID
    step("sh.idle", 1'b1, 2'b00, S_IDLE, O_START);
    step("sh.lsb",  1'b0, 2'b00, S_LSB,  O_LSB);
    step("sh.mid",  1'b0, 2'b10, S_MID,  O_MID2);
    step("sh.msb",  1'b0, 2'b11, S_MSB,  O_MSB);
    step("sh.done", 1'b0, 2'b00, S_DONE, O_DONE);
    step("sh.back", 1'b0, 2'b00, S_IDLE, O_DEF);

    // start held past the IDLE->LSB edge
    step("sh2.idle", 1'b1, 2'b00, S_IDLE, O_START);
    step("sh2.lsb",  1'b1, 2'b00, S_LSB,  O_DEF);
    step("sh2.err",  1'b1, 2'b00, S_ERR,  O_START);
    step("sh2.rlsb", 1'b0, 2'b00, S_LSB,  O_LSB);

    // Bad count in MSB, ERR holds with start low
    step("bc.mid",  1'b0, 2'b10, S_MID, O_MID2);
    step("bc.msb",  1'b0, 2'b10, S_MSB, O_DEF);
    step("bc.err0", 1'b0, 2'b00, S_ERR, O_DEF);
    step("bc.err1", 1'b0, 2'b11, S_ERR, O_DEF);
    step("bc.err2", 1'b0, 2'b01, S_ERR, O_DEF);

    // start during CALC_DONE
    step("cd.err",  1'b1, 2'b00, S_ERR,  O_START);
    step("cd.lsb",  1'b0, 2'b00, S_LSB,  O_LSB);
    step("cd.mid",  1'b0, 2'b10, S_MID,  O_MID2);
    step("cd.msb",  1'b0, 2'b11, S_MSB,  O_MSB);
    step("cd.done", 1'b1, 2'b00, S_DONE, O_DEF);
    step("cd.err2", 1'b0, 2'b00, S_ERR,  O_DEF);

    // Back-to-back runs
    step("bb.err",   1'b1, 2'b00, S_ERR,  O_START);
    step("bb.lsb1",  1'b0, 2'b00, S_LSB,  O_LSB);
    step("bb.mid1",  1'b0, 2'b01, S_MID,  O_MID1);
    step("bb.mid1b", 1'b0, 2'b10, S_MID,  O_MID2);
    step("bb.msb1",  1'b0, 2'b11, S_MSB,  O_MSB);
    step("bb.done1", 1'b0, 2'b00, S_DONE, O_DONE);
    step("bb.idle",  1'b1, 2'b00, S_IDLE, O_START);
    step("bb.lsb2",  1'b0, 2'b00, S_LSB,  O_LSB);
    step("bb.mid2",  1'b0, 2'b01, S_MID,  O_MID1);
    step("bb.mid2b", 1'b0, 2'b10, S_MID,  O_MID2);
    step("bb.msb2",  1'b0, 2'b11, S_MSB,  O_MSB);
    step("bb.done2", 1'b0, 2'b00, S_DONE, O_DONE);
    step("bb.end",   1'b0, 2'b00, S_IDLE, O_DEF);

    // Asynchronous reset from MID, without waiting for a clock edge
    step("ar.idle", 1'b1, 2'b00, S_IDLE, O_START);
    step("ar.lsb",  1'b0, 2'b00, S_LSB,  O_LSB);
    step("ar.mid",  1'b0, 2'b01, S_MID,  O_MID1);
    reset_a = 1'b0;
    #1;
    check_vec("ar.state", {13'd0, state_out}, {13'd0, S_IDLE});
    check_vec("ar.outs", {9'd0, done, clk_ena, sclr_n, input_sel, shift_sel}, {9'd0, O_DEF});
    @(negedge clk);
    reset_a = 1'b1;
    step("ar.after", 1'b0, 2'b00, S_IDLE, O_DEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
